// File: rtl/uart_rx_datapath_pkg.sv
// rtl/uart_rx_datapath_pkg.sv - shared types, line levels and state codes for the UART receive path
package uart_rx_datapath_pkg;

  typedef logic [7:0] uart_data_t;

  // Line levels of the framing bits
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  // Receiver FSM state codes
  typedef logic [2:0] uart_rx_state_t;
  localparam uart_rx_state_t ST_IDLE   = 3'd0;
  localparam uart_rx_state_t ST_START  = 3'd1;
  localparam uart_rx_state_t ST_DATA   = 3'd2;
  localparam uart_rx_state_t ST_PARITY = 3'd3;
  localparam uart_rx_state_t ST_STOP   = 3'd4;

  // Keeps only the low nbits of a character (nbits is 5..8 wherever this is used)
  function automatic uart_data_t data_mask(input logic [3:0] nbits);
    return uart_data_t'(8'hFF >> (4'd8 - nbits));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - multi-flop synchronizer for an asynchronous idle-high input
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the async input through the chain; reset to the idle-high line level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_datapath.sv
// rtl/uart_rx_datapath.sv - UART receiver: start detect, mid-bit sampling, parity/framing check, status
module uart_rx_datapath
  import uart_rx_datapath_pkg::*;
#(
  parameter int BAUD_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic [BAUD_W-1:0] baud_count,
  input  logic [3:0]        data_bits,
  input  logic              parity_en,
  input  logic              odd_parity,
  input  logic              rx_read,
  input  logic              overrun_clr,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              rx_full,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  logic           rx_s;
  logic           rx_s_d;
  uart_rx_state_t state;
  logic [BAUD_W-1:0] cnt;
  logic [BAUD_W-1:0] baud_q;
  logic [3:0]     nbits_q;
  logic           par_en_q;
  logic           odd_q;
  logic [2:0]     bit_idx;
  uart_data_t     shreg;
  logic           p_err;

  logic tick;
  logic cfg_ok;
  logic start_ok;
  logic last_bit;
  logic deliver;
  logic data_parity;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign tick        = (cnt == '0);
  assign cfg_ok      = (baud_count >= BAUD_W'(4)) && (data_bits >= 4'd5) && (data_bits <= 4'd8);
  assign start_ok    = (state == ST_IDLE) && rx_s_d && !rx_s && cfg_ok;
  assign last_bit    = ({1'b0, bit_idx} == (nbits_q - 4'd1));
  assign deliver     = (state == ST_STOP) && tick;
  assign data_parity = ^(shreg & data_mask(nbits_q));
  assign busy        = (state != ST_IDLE);

  // Delayed copy of the synchronized line for falling-edge start detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s_d <= 1'b1;
    end else begin
      rx_s_d <= rx_s;
    end
  end

  // Bit timer: half a bit to the start-bit centre, then one full bit per sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start_ok) begin
      cnt <= (baud_count >> 1) - BAUD_W'(1);
    end else if (state != ST_IDLE) begin
      cnt <= tick ? (baud_q - BAUD_W'(1)) : (cnt - BAUD_W'(1));
    end
  end

  // Frame FSM with shadowed configuration and LSB-first shift register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_q   <= '0;
      nbits_q  <= '0;
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
      bit_idx  <= '0;
      shreg    <= '0;
      p_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            baud_q   <= baud_count;
            nbits_q  <= data_bits;
            par_en_q <= parity_en;
            odd_q    <= odd_parity;
            bit_idx  <= '0;
            shreg    <= '0;
            p_err    <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_s == UART_START_BIT) begin
              bit_idx <= '0;
              state   <= ST_DATA;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shreg[bit_idx] <= rx_s;
            if (last_bit) begin
              state <= par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            p_err <= ((data_parity ^ rx_s) != odd_q);
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Character delivery and sticky full/overrun status toward the CSR block
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_full    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_valid <= deliver;
      if (deliver) begin
        rx_data    <= shreg & data_mask(nbits_q);
        parity_err <= p_err & par_en_q;
        frame_err  <= (rx_s != UART_STOP_BIT);
        rx_full    <= 1'b1;
      end else if (rx_read) begin
        rx_full <= 1'b0;
      end
      if (deliver && rx_full && !rx_read) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
